// File: rtl/motor_pkg.sv
// Shared motion codes and sequencer state encoding for the motor control path.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package motor_pkg;

    // One-hot motion command; bits [5:4] are reserved and always 0.
    typedef logic [5:0] motion_t;

    localparam motion_t MOT_STOP  = 6'd0;
    localparam motion_t MOT_FWD   = 6'd1;
    localparam motion_t MOT_BWD   = 6'd2;
    localparam motion_t MOT_RIGHT = 6'd4;
    localparam motion_t MOT_LEFT  = 6'd8;

    typedef enum logic [1:0] {
        S_STOP  = 2'd0,
        S_DRIVE = 2'd1,
        S_DEAD  = 2'd2,
        S_FAULT = 2'd3
    } seq_state_t;

    // Debounced switch vector {left,right,backward,forward} to a motion request.
    // Zero or several pressed switches are treated as a stop request.
    function automatic motion_t decode_req(input logic [3:0] sw_db);
        motion_t m;
        m = MOT_STOP;
        case (sw_db)
            4'b0001: m = MOT_FWD;
            4'b0010: m = MOT_BWD;
            4'b0100: m = MOT_RIGHT;
            4'b1000: m = MOT_LEFT;
            default: m = MOT_STOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cmd_debounce.sv
// Single-bit 2-FF synchronizer followed by a hold-time debouncer.
// Latency: 2 sync cycles + CYCLES cycles of stable input before dout flips.
// Backpressure: none; free-running, any bounce restarts the hold count.
module cmd_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int            CW     = $clog2(CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

    logic          din_s1;
    logic          din_s2;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous switch into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
        end
    end

    // Count down while the synced input disagrees with dout; flip on the
    // CYCLES-th consecutive disagreeing cycle, reload whenever they agree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din_s2 == dout) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            dout <= din_s2;
            cnt  <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// Turns debounced direction switches into a one-hot motion command with forced dead-time and over-current lockout.
// Latency: switch edge to command 2+DEBOUNCE_CYCLES+1 cycles; over-current to stop at most 3 cycles.
// Backpressure: none; requests arriving during dead-time or lockout are ignored until they expire.
module motion_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEAD_CYCLES     = 5_000_000,
    parameter int RETRY_CYCLES    = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       comp_a,
    input  logic       comp_b,
    output logic [5:0] state,
    output logic       busy,
    output logic       fault
);

    // All intervals must be at least 1; a value of 1 means a single cycle.
    localparam int            DW          = $clog2(DEAD_CYCLES) + 1;
    localparam int            RW          = $clog2(RETRY_CYCLES) + 1;
    localparam logic [DW-1:0] DEAD_RELOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [RW-1:0] RTRY_RELOAD = RW'(RETRY_CYCLES - 1);

    logic [3:0]    sw_db;
    motion_t       req;
    logic [1:0]    oc_a_sync;
    logic [1:0]    oc_b_sync;
    logic          ocp;

    seq_state_t    st, st_nxt;
    motion_t       cur, cur_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_db
            cmd_debounce #(
                .CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (sw[i]),
                .dout    (sw_db[i])
            );
        end
    endgenerate

    assign req = decode_req(sw_db);

    // Comparator synchronizers carry the inverted (fault-active-high) level so
    // that clearing them on reset means "no over-current" rather than a fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oc_a_sync <= 2'b00;
            oc_b_sync <= 2'b00;
        end else begin
            oc_a_sync <= {oc_a_sync[0], ~comp_a};
            oc_b_sync <= {oc_b_sync[0], ~comp_b};
        end
    end

    // Equivalent to !(comp_a_sync & comp_b_sync); deliberately not debounced.
    assign ocp = oc_a_sync[1] | oc_b_sync[1];

    // Sequencer state, current motion and interval counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st   <= S_STOP;
            cur  <= MOT_STOP;
            dcnt <= '0;
            rcnt <= '0;
        end else begin
            st   <= st_nxt;
            cur  <= cur_nxt;
            dcnt <= dcnt_nxt;
            rcnt <= rcnt_nxt;
        end
    end

    // Next-state logic; over-current outranks every other transition,
    // including a dead-time expiry in the same cycle.
    always_comb begin
        st_nxt   = st;
        cur_nxt  = cur;
        dcnt_nxt = dcnt;
        rcnt_nxt = rcnt;
        if (ocp) begin
            st_nxt   = S_FAULT;
            rcnt_nxt = RTRY_RELOAD;
        end else begin
            case (st)
                S_STOP: begin
                    if (req != MOT_STOP) begin
                        st_nxt  = S_DRIVE;
                        cur_nxt = req;
                    end
                end
                S_DRIVE: begin
                    if (req != cur) begin
                        st_nxt   = S_DEAD;
                        dcnt_nxt = DEAD_RELOAD;
                    end
                end
                S_DEAD: begin
                    // Request is only looked at on expiry; changes during the
                    // interval never restart it.
                    if (dcnt == '0) begin
                        if (req == MOT_STOP) begin
                            st_nxt = S_STOP;
                        end else begin
                            st_nxt  = S_DRIVE;
                            cur_nxt = req;
                        end
                    end else begin
                        dcnt_nxt = dcnt - DW'(1);
                    end
                end
                S_FAULT: begin
                    // Leave only once the lockout has elapsed and the operator
                    // has released every switch.
                    if (rcnt != '0) begin
                        rcnt_nxt = rcnt - RW'(1);
                    end else if (req == MOT_STOP) begin
                        st_nxt  = S_STOP;
                        cur_nxt = MOT_STOP;
                    end
                end
                default: begin
                    st_nxt = S_STOP;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        state = MOT_STOP;
        busy  = 1'b0;
        fault = 1'b0;
        case (st)
            S_DRIVE: state = cur;
            S_DEAD:  busy  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: state = MOT_STOP;
        endcase
    end

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
module tb_motion_cmd_sequencer;
    import motor_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic       comp_a = 1'b1;
    logic       comp_b = 1'b1;
    logic [5:0] state;
    logic       busy;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    motion_cmd_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .DEAD_CYCLES     (8),
        .RETRY_CYCLES    (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .comp_a  (comp_a),
        .comp_b  (comp_b),
        .state   (state),
        .busy    (busy),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    // One row: drive inputs at a falling edge, wait cyc falling edges, compare.
    typedef struct {
        logic [3:0] sw;
        logic       ca;
        logic       cb;
        int         cyc;
        logic [5:0] st;
        logic       busy;
        logic       fault;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] s, input logic a, input logic b, input int c,
                       input logic [5:0] es, input logic eb, input logic ef);
        vec_t v;
        v.sw = s; v.ca = a; v.cb = b; v.cyc = c;
        v.st = es; v.busy = eb; v.fault = ef;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [5:0] es, input logic eb, input logic ef);
        n_tests++;
        if (state !== es || busy !== eb || fault !== ef) begin
            n_fail++;
            $display("FAIL %s: got state=%0d busy=%b fault=%b, expected state=%0d busy=%b fault=%b",
                     nm, state, busy, fault, es, eb, ef);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sw      = 4'b0000;
        comp_a  = 1'b1;
        comp_b  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", MOT_STOP, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        // Switch to drive: 2 sync + 4 debounce + 1 FSM = 7 cycles.
        add(4'b0000, 1, 1, 2,  MOT_STOP, 0, 0);
        add(4'b0001, 1, 1, 6,  MOT_STOP, 0, 0);
        add(4'b0001, 1, 1, 1,  MOT_FWD,  0, 0);
        // Fwd -> bwd: 8 stopped busy cycles, then bwd.
        add(4'b0010, 1, 1, 6,  MOT_FWD,  0, 0);
        add(4'b0010, 1, 1, 1,  MOT_STOP, 1, 0);
        add(4'b0010, 1, 1, 7,  MOT_STOP, 1, 0);
        add(4'b0010, 1, 1, 1,  MOT_BWD,  0, 0);
        // Two switches pressed: dead-time then stop.
        add(4'b0011, 1, 1, 6,  MOT_BWD,  0, 0);
        add(4'b0011, 1, 1, 1,  MOT_STOP, 1, 0);
        add(4'b0011, 1, 1, 7,  MOT_STOP, 1, 0);
        add(4'b0011, 1, 1, 1,  MOT_STOP, 0, 0);
        add(4'b0011, 1, 1, 4,  MOT_STOP, 0, 0);
        add(4'b0000, 1, 1, 10, MOT_STOP, 0, 0);
        // Multi-switch from stop never drives.
        add(4'b0101, 1, 1, 12, MOT_STOP, 0, 0);
        add(4'b0000, 1, 1, 10, MOT_STOP, 0, 0);
        // Over-current while driving, held switch keeps the lockout.
        add(4'b0001, 1, 1, 7,  MOT_FWD,  0, 0);
        add(4'b0001, 0, 1, 1,  MOT_FWD,  0, 0);
        add(4'b0001, 1, 1, 1,  MOT_FWD,  0, 0);
        add(4'b0001, 1, 1, 1,  MOT_STOP, 0, 1);
        add(4'b0001, 1, 1, 30, MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 6,  MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 1,  MOT_STOP, 0, 0);
        // Lockout length from stop: exactly 16 cycles.
        add(4'b0000, 1, 0, 1,  MOT_STOP, 0, 0);
        add(4'b0000, 1, 1, 2,  MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 15, MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 1,  MOT_STOP, 0, 0);
        // Over-current coinciding with dead-time expiry wins.
        add(4'b0001, 1, 1, 7,  MOT_FWD,  0, 0);
        add(4'b0000, 1, 1, 7,  MOT_STOP, 1, 0);
        add(4'b0000, 1, 1, 5,  MOT_STOP, 1, 0);
        add(4'b0000, 0, 1, 1,  MOT_STOP, 1, 0);
        add(4'b0000, 1, 1, 1,  MOT_STOP, 1, 0);
        add(4'b0000, 1, 1, 1,  MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 15, MOT_STOP, 0, 1);
        add(4'b0000, 1, 1, 1,  MOT_STOP, 0, 0);

        @(negedge clk);
        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            sw     = tbl[k].sw;
            comp_a = tbl[k].ca;
            comp_b = tbl[k].cb;
            repeat (tbl[k].cyc) @(negedge clk);
            check($sformatf("vec%0d", k), tbl[k].st, tbl[k].busy, tbl[k].fault);
        end

        // Bouncing switch, 2-cycle pulses, must never be accepted.
        for (int k = 0; k < 10; k++) begin
            sw = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            repeat (2) @(negedge clk);
            check($sformatf("bounce%0d", k), MOT_STOP, 1'b0, 1'b0);
        end
        sw = 4'b0000;
        repeat (10) @(negedge clk);
        check("bounce_settle", MOT_STOP, 1'b0, 1'b0);

        // Reset during dead-time clears outputs asynchronously.
        do_reset();
        sw = 4'b0001;
        repeat (7) @(negedge clk);
        check("rst_drive", MOT_FWD, 1'b0, 1'b0);
        sw = 4'b0000;
        repeat (7) @(negedge clk);
        check("rst_dead", MOT_STOP, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_async_dead", MOT_STOP, 1'b0, 1'b0);
        sw = 4'b0001;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("rst_redrive%0d", k), (k == 7) ? MOT_FWD : MOT_STOP, 1'b0, 1'b0);
        end

        // Reset during lockout clears fault asynchronously.
        comp_b = 1'b0;
        repeat (3) @(negedge clk);
        comp_b = 1'b1;
        check("rst_fault", MOT_STOP, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("rst_async_fault", MOT_STOP, 1'b0, 1'b0);
        sw = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_after_fault", MOT_STOP, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
